reset_sequencer: RTL and testbench

//   Ordered reset release for NUM_DOMAINS downstream blocks, each normally behind a
//   per-domain reset synchronizer. Asserts all domain resets together, holds them,

---
 rtl/reset_sequencer.sv | 165 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer
// Ordered reset release for NUM_DOMAINS downstream blocks. All domain resets
// assert together and stay asserted for HOLD_CYCLES. They are then released one
// at a time, lowest index first. Each release after the first waits for at
// least GAP_CYCLES and for the current domain's ready bit. If the ready bit
// does not arrive, the release happens after TIMEOUT_CYCLES instead and a
// sticky per-domain timeout flag is set. A software request issued while idle
// re-runs the whole sequence.
//
// Handshake: sw_rst_req is a level/pulse with no ready. It is acted on only
// at an edge that samples the FSM in IDLE. At any other edge it is dropped,
// not queued. domain_ready is sampled only for the domain currently being
// released.
module reset_sequencer #(
  parameter int NUM_DOMAINS    = 4,
  parameter int HOLD_CYCLES    = 8,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   sw_rst_req,
  input  logic [NUM_DOMAINS-1:0] domain_ready,
  output logic [NUM_DOMAINS-1:0] OUT_RST,
  output logic                   busy,
  output logic                   seq_done,
  output logic [NUM_DOMAINS-1:0] timeout_err,
  output logic [1:0]             dbg_state
);

  // One counter serves both the hold phase and every wait step. It is sized
  // for the longer of the two so that a long hold cannot overflow it.
  localparam int CNT_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_WAIT = 2'd1,
    ST_IDLE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] out_rst_q, out_rst_d;
  logic [NUM_DOMAINS-1:0] terr_q, terr_d;
  logic                   done_q, done_d;

  logic                   ready_cur;
  logic                   gap_met;
  logic                   ready_ok;
  logic                   to_hit;
  logic                   advance;
  logic [IDX_W-1:0]       next_idx;

  // State register: RST wins over everything and restarts the hold phase
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      out_rst_q <= '1;
      terr_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      out_rst_q <= out_rst_d;
      terr_q    <= terr_d;
      done_q    <= done_d;
    end
  end

  // Step-advance conditions for the domain currently being released
  always_comb begin
    ready_cur = 1'b0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      if (i == int'(idx_q)) ready_cur = domain_ready[i];
    end
    gap_met  = (cnt_q >= GAP_LAST);
    ready_ok = gap_met && ready_cur;
    to_hit   = (cnt_q == TO_LAST);
    advance  = ready_ok || to_hit;
    next_idx = idx_q + IDX_W'(1);
  end

  // Next-state logic: hold, per-domain wait/release, idle with soft restart
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    out_rst_d = out_rst_q;
    terr_d    = terr_q;
    done_d    = 1'b0;
    case (state_q)
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          out_rst_d[0] = 1'b0;
          idx_d        = '0;
          cnt_d        = '0;
          state_d      = ST_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (advance) begin
          // A release forced by the timeout flags the domain that never came up
          if (!ready_ok) begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
              if (i == int'(idx_q)) terr_d[i] = 1'b1;
            end
          end
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = next_idx;
            for (int i = 0; i < NUM_DOMAINS; i++) begin
              if (i == int'(next_idx)) out_rst_d[i] = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        cnt_d     = '0;
        out_rst_d = '0;
        if (sw_rst_req) begin
          out_rst_d = '1;
          state_d   = ST_HOLD;
          cnt_d     = '0;
          idx_d     = '0;
          terr_d    = '0;
        end
      end
      default: begin
        // Unreachable encoding: recover by restarting the full sequence
        out_rst_d = '1;
        state_d   = ST_HOLD;
        cnt_d     = '0;
        idx_d     = '0;
      end
    endcase
  end

  // Outputs: registered resets/flags, busy decoded from the state register
  always_comb begin
    OUT_RST     = out_rst_q;
    timeout_err = terr_q;
    seq_done    = done_q;
    busy        = (state_q != ST_IDLE);
    dbg_state   = state_q;
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a default 4-domain instance and a
// 1-domain instance with HOLD=1, GAP=1. Edge numbers in the tasks count
// posedges after the last edge that sampled RST=1 (or the sw_rst_req edge).
module tb_reset_sequencer;

  localparam logic [1:0] S_HOLD = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd2;

  logic       clk;
  logic       rst, sw_req;
  logic [3:0] ready, out_rst, terr;
  logic       busy, done;
  logic [1:0] st;

  logic       rst1, sw_req1;
  logic [0:0] ready1, out_rst1, terr1;
  logic       busy1, done1;
  logic [1:0] st1;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(
    .NUM_DOMAINS(4), .HOLD_CYCLES(8), .GAP_CYCLES(4), .TIMEOUT_CYCLES(32)
  ) u_dut (
    .CLK(clk), .RST(rst), .sw_rst_req(sw_req), .domain_ready(ready),
    .OUT_RST(out_rst), .busy(busy), .seq_done(done), .timeout_err(terr),
    .dbg_state(st)
  );

  reset_sequencer #(
    .NUM_DOMAINS(1), .HOLD_CYCLES(1), .GAP_CYCLES(1), .TIMEOUT_CYCLES(32)
  ) u_dut1 (
    .CLK(clk), .RST(rst1), .sw_rst_req(sw_req1), .domain_ready(ready1),
    .OUT_RST(out_rst1), .busy(busy1), .seq_done(done1), .timeout_err(terr1),
    .dbg_state(st1)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge and settle before sampling or driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] e;
    rst = 1'b1; ready = 4'hF;
    repeat (3) tick();
    checks++; if (out_rst !== 4'hF) begin errors++; $display("FAIL por_out_rst got %h exp %h", out_rst, 4'hF); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL por_busy got %b exp 1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL por_done got %b exp 0", done); end
    checks++; if (terr !== 4'h0) begin errors++; $display("FAIL por_terr got %h exp 0", terr); end
    checks++; if (st !== S_HOLD) begin errors++; $display("FAIL por_state got %0d exp %0d", st, S_HOLD); end
    rst = 1'b0;
    for (int n = 1; n <= 26; n++) begin
      tick();
      for (int i = 0; i < 4; i++) e[i] = (n < 8 + 4 * i) ? 1'b1 : 1'b0;
      checks++; if (out_rst !== e) begin errors++; $display("FAIL seq_out_rst edge %0d got %h exp %h", n, out_rst, e); end
      checks++; if (done !== (n == 24)) begin errors++; $display("FAIL seq_done edge %0d got %b exp %b", n, done, (n == 24)); end
      checks++; if (busy !== (n < 24)) begin errors++; $display("FAIL seq_busy edge %0d got %b exp %b", n, busy, (n < 24)); end
    end
    checks++; if (terr !== 4'h0) begin errors++; $display("FAIL seq_terr got %h exp 0", terr); end
  endtask

  task automatic test_late_ready();
    rst = 1'b1; ready = 4'b1101;
    tick();
    rst = 1'b0;
    repeat (12) tick();
    checks++; if (out_rst !== 4'b1100) begin errors++; $display("FAIL late_bit1_fall got %h exp %h", out_rst, 4'b1100); end
    repeat (10) tick();
    checks++; if (out_rst !== 4'b1100) begin errors++; $display("FAIL late_held got %h exp %h", out_rst, 4'b1100); end
    ready = 4'hF;
    tick();
    checks++; if (out_rst !== 4'b1000) begin errors++; $display("FAIL late_bit2_fall got %h exp %h", out_rst, 4'b1000); end
    repeat (3) tick();
    checks++; if (out_rst !== 4'b1000) begin errors++; $display("FAIL late_gap got %h exp %h", out_rst, 4'b1000); end
    tick();
    checks++; if (out_rst !== 4'b0000) begin errors++; $display("FAIL late_bit3_fall got %h exp 0", out_rst); end
    repeat (3) tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL late_done_early got %b exp 0", done); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL late_done got %b exp 1", done); end
    checks++; if (terr !== 4'h0) begin errors++; $display("FAIL late_terr got %h exp 0", terr); end
  endtask

  task automatic test_dead_domain();
    rst = 1'b1; ready = 4'b1011;
    tick();
    rst = 1'b0;
    repeat (16) tick();
    checks++; if (out_rst !== 4'b1000) begin errors++; $display("FAIL dead_bit2_fall got %h exp %h", out_rst, 4'b1000); end
    repeat (31) tick();
    checks++; if (out_rst !== 4'b1000) begin errors++; $display("FAIL dead_before_to got %h exp %h", out_rst, 4'b1000); end
    checks++; if (terr !== 4'h0) begin errors++; $display("FAIL dead_terr_early got %h exp 0", terr); end
    tick();
    checks++; if (out_rst !== 4'b0000) begin errors++; $display("FAIL dead_bit3_fall got %h exp 0", out_rst); end
    checks++; if (terr !== 4'b0100) begin errors++; $display("FAIL dead_terr got %h exp %h", terr, 4'b0100); end
    repeat (3) tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL dead_done_early got %b exp 0", done); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL dead_done got %b exp 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dead_busy got %b exp 0", busy); end
    repeat (5) tick();
    checks++; if (terr !== 4'b0100) begin errors++; $display("FAIL dead_terr_sticky got %h exp %h", terr, 4'b0100); end
    checks++; if (out_rst !== 4'h0) begin errors++; $display("FAIL idle_out_rst got %h exp 0", out_rst); end
    checks++; if (st !== S_IDLE) begin errors++; $display("FAIL idle_state got %0d exp %0d", st, S_IDLE); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL idle_done got %b exp 0", done); end
  endtask

  task automatic test_soft_reset();
    ready = 4'hF;
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    checks++; if (out_rst !== 4'hF) begin errors++; $display("FAIL sw_out_rst got %h exp %h", out_rst, 4'hF); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sw_busy got %b exp 1", busy); end
    checks++; if (terr !== 4'h0) begin errors++; $display("FAIL sw_terr_clear got %h exp 0", terr); end
    checks++; if (st !== S_HOLD) begin errors++; $display("FAIL sw_state got %0d exp %0d", st, S_HOLD); end
    repeat (3) tick();
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    checks++; if (st !== S_HOLD) begin errors++; $display("FAIL sw2_state got %0d exp %0d", st, S_HOLD); end
    repeat (3) tick();
    checks++; if (out_rst !== 4'hF) begin errors++; $display("FAIL sw2_hold got %h exp %h", out_rst, 4'hF); end
    tick();
    checks++; if (out_rst !== 4'hE) begin errors++; $display("FAIL sw2_bit0_fall got %h exp %h", out_rst, 4'hE); end
    repeat (15) tick();
    sw_req = 1'b1;
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL sw_done got %b exp 1", done); end
    checks++; if (st !== S_IDLE) begin errors++; $display("FAIL sw_enter_idle got %0d exp %0d", st, S_IDLE); end
    sw_req = 1'b0;
    tick();
    checks++; if (st !== S_IDLE) begin errors++; $display("FAIL sw_entry_ignored got %0d exp %0d", st, S_IDLE); end
    checks++; if (out_rst !== 4'h0) begin errors++; $display("FAIL sw_entry_out got %h exp 0", out_rst); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sw_entry_busy got %b exp 0", busy); end
  endtask

  task automatic test_mid_rst();
    ready = 4'hF;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (17) tick();
    checks++; if (out_rst !== 4'b1000) begin errors++; $display("FAIL mid_pre got %h exp %h", out_rst, 4'b1000); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_rst !== 4'hF) begin errors++; $display("FAIL mid_out_rst got %h exp %h", out_rst, 4'hF); end
    checks++; if (st !== S_HOLD) begin errors++; $display("FAIL mid_state got %0d exp %0d", st, S_HOLD); end
    for (int n = 1; n <= 24; n++) begin
      tick();
      checks++; if (done !== (n == 24)) begin errors++; $display("FAIL mid_done edge %0d got %b exp %b", n, done, (n == 24)); end
      if (n == 7) begin
        checks++; if (out_rst !== 4'hF) begin errors++; $display("FAIL mid_hold got %h exp %h", out_rst, 4'hF); end
      end
      if (n == 8) begin
        checks++; if (out_rst !== 4'hE) begin errors++; $display("FAIL mid_bit0_fall got %h exp %h", out_rst, 4'hE); end
      end
    end
  endtask

  task automatic test_single_domain();
    rst1 = 1'b1; ready1 = 1'b1;
    repeat (2) tick();
    checks++; if (out_rst1 !== 1'b1) begin errors++; $display("FAIL one_rst_out got %b exp 1", out_rst1); end
    rst1 = 1'b0;
    tick();
    checks++; if (out_rst1 !== 1'b0) begin errors++; $display("FAIL one_bit0_fall got %b exp 0", out_rst1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL one_done_early got %b exp 0", done1); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL one_busy got %b exp 1", busy1); end
    tick();
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL one_done got %b exp 1", done1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL one_busy_fall got %b exp 0", busy1); end
    tick();
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL one_done_pulse got %b exp 0", done1); end
    checks++; if (terr1 !== 1'b0) begin errors++; $display("FAIL one_terr got %b exp 0", terr1); end
  endtask

  // Test sequence and final report
  initial begin
    rst = 1'b1; sw_req = 1'b0; ready = 4'hF;
    rst1 = 1'b1; sw_req1 = 1'b0; ready1 = 1'b1;
    test_reset();
    test_late_ready();
    test_dead_domain();
    test_soft_reset();
    test_mid_rst();
    test_single_domain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
